uart_tx_word: RTL
=================

// Module: uart_tx_word
// PURPOSE
//   UART transmitter, companion to the program-download receiver. Accepts a 32-bit word over a
//   valid/ready handshake and serialises it as 4 back-to-back 8N1 frames, MSB byte first, so a
//   word sent here is rebuilt unchanged by the receiver ({acc[23:0], byte} packing).
//   Sits on the peripheral side, driving the board uart_tx pin (status/readback to the host PC).
// PARAMETERS
//   CLK_FREQ      50_000_000  system clock frequency in Hz (`CLK_FREQ)
//   UART_BPS      9600        baud rate (`UART_BPS)
//   BAUD_CNT_MAX  CLK_FREQ/UART_BPS (5208)  clocks per bit; must be >= 2 and < 2**16
// PORTS
//   clk          in   1   system clock, all logic on posedge
//   rst_n        in   1   asynchronous active-low reset
//   tx_data_i    in   32  word to transmit; sampled only on accept
//   tx_valid_i   in   1   request; word accepted when tx_valid_i && tx_ready_o at posedge clk
//   tx_ready_o   out  1   high when idle and able to accept a word
//   tx_busy_o    out  1   high from the cycle after accept until the last stop bit ends
//   tx_done_o    out  1   one-cycle pulse when the 4th byte's stop bit completes
//   uart_tx      out  1   serial line, idle high
// BEHAVIOUR
//   Reset: uart_tx=1, tx_ready_o=1, tx_busy_o=0, tx_done_o=0, state=IDLE, all counters 0.
//   Reset asserted mid-word aborts at once: line returns high asynchronously; no done pulse.
//   States: IDLE -> START -> DATA -> [PARITY] -> STOP -> (START | IDLE).
//     IDLE : uart_tx=1, ready=1. On accept: latch tx_data_i into shift reg, byte_cnt=0,
//            baud_cnt=0, go START. uart_tx falls in the cycle after accept (latency 1).
//     START: uart_tx=0 for BAUD_CNT_MAX clocks, then DATA with bit_cnt=0.
//     DATA : uart_tx = current byte bit[bit_cnt], LSB first, each held BAUD_CNT_MAX clocks;
//            after bit 7 go PARITY (if enabled) else STOP.
//     STOP : uart_tx=1 for BAUD_CNT_MAX clocks. At end: byte_cnt<3 -> byte_cnt+1, next byte,
//            START (no idle gap); byte_cnt==3 -> IDLE, tx_done_o=1 for that one cycle.
//   Byte order: byte0=word[31:24], byte1=[23:16], byte2=[15:8], byte3=[7:0].
//   baud_cnt counts 0..BAUD_CNT_MAX-1, wraps to 0 on each bit boundary; held at 0 in IDLE.
//   Word duration = 4*10*BAUD_CNT_MAX clocks (4*11*BAUD_CNT_MAX with parity), accept to done.
//   tx_ready_o is registered; it rises in the cycle after the done pulse, so a new word can be
//   accepted at the earliest one cycle after tx_done_o (one-bit-clock idle gap minimum is NOT
//   required; line stays high between words).
//   tx_valid_i while busy is ignored; tx_data_i changes after accept have no effect.
//   uart_tx is driven from a register (glitch-free); no combinational path input -> uart_tx.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: PARITY state inserted after bit 7 of every byte, one bit time,
//     uart_tx = ^byte (even parity); frame becomes 8E1.
//   UART_TX_PARITY_EN undefined: no PARITY state, frame is 8N1 (matches download receiver).
// TESTING  (bench uses CLK_FREQ=1000, UART_BPS=100 -> BAUD_CNT_MAX=10)
//   Reset: hold rst_n=0 -> uart_tx=1, tx_ready_o=1, tx_busy_o=0, tx_done_o=0.
//   Send 0x12345678: sampling uart_tx at mid-bit (count 5) decodes bytes 0x12,0x34,0x56,0x78,
//     each 0 + LSB-first data + 1; tx_done_o pulses exactly 400 clocks after accept cycle+1.
//   Loopback to download receiver: send 0xDEADBEEF then 0x00000013 -> receiver rom_wr_data_o
//     shows 0xDEADBEEF then 0x00000013, addresses 0 and 4.
//   Valid during busy: assert tx_valid_i with 0xFFFFFFFF 50 clocks into a word -> ignored,
//     ready stays 0, serial stream of first word unaltered; then accepted after tx_done_o.
//   Reset mid-word: drop rst_n at clock 123 of a word -> uart_tx=1 immediately, no tx_done_o;
//     after release next word 0xA5A5A5A5 transmits correctly from byte 0.
//   UART_TX_PARITY_EN: send 0x01030700 -> parity bits 1,0,1,0; word takes 440 clocks.

Source files
------------

// File: rtl/uart_tx_word.sv
// uart_tx_word: serialises a 32-bit word as four back-to-back UART frames,
// MSB byte first and LSB-first bits within each byte. The line idles high.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after bit 7 of every byte (8E1 frames). Without it the frames are 8N1,
// which matches the download receiver.
module uart_tx_word #(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int UART_BPS     = 9600,
   parameter int BAUD_CNT_MAX = CLK_FREQ / UART_BPS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] tx_data_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   output logic        tx_busy_o,
   output logic        tx_done_o,
   output logic        uart_tx
);

   // Last baud_cnt value of a bit time; a bit boundary occurs when it is reached.
   localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        baud_end;
   logic [7:0]  cur_byte;

   assign baud_end = (baud_cnt_q == BAUD_LAST);
   // The byte on the wire always sits in the top of the shift register.
   assign cur_byte = shift_q[31:24];

   // State and datapath registers; the line is registered so it cannot glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic; the next line level is decided together with the
   // transition so uart_tx changes in the same cycle the new bit time begins.
   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            baud_cnt_d = '0;
            tx_d       = 1'b1;
            if (tx_valid_i && ready_q) begin
               shift_d    = tx_data_i;
               byte_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = START;
               tx_d       = 1'b0;
            end
         end

         START: begin
            if (baud_end) begin
               baud_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = DATA;
               tx_d       = cur_byte[0];
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end

         DATA: begin
            if (baud_end) begin
               baud_cnt_d = '0;
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = ^cur_byte;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  tx_d      = cur_byte[bit_cnt_d];
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_end) begin
               baud_cnt_d = '0;
               state_d    = STOP;
               tx_d       = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end
`endif

         STOP: begin
            if (baud_end) begin
               baud_cnt_d = '0;
               if (byte_cnt_q == 2'd3) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  tx_d    = 1'b1;
               end else begin
                  // Next byte starts immediately: no idle gap inside a word.
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  shift_d    = {shift_q[23:0], 8'h00};
                  state_d    = START;
                  tx_d       = 1'b0;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 16'd1;
            end
         end

         default: begin
            state_d    = IDLE;
            baud_cnt_d = '0;
            tx_d       = 1'b1;
         end
      endcase

      // Ready is held low during the done cycle so it rises one cycle later.
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE) && !done_d;
   end

   assign uart_tx    = tx_q;
   assign tx_ready_o = ready_q;
   assign tx_busy_o  = busy_q;
   assign tx_done_o  = done_q;

endmodule
